// File: rtl/mul_flag_unit_if.sv
// rtl/mul_flag_unit_if.sv - pipeline-side handshake and data bundle for the iterative multiplier
interface mul_flag_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_acc;
  logic             accumulate;
  logic             set_flags;
  logic [1:0]       old_cv;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [3:0]       alu_flags;
  logic [1:0]       flag_w;

  // Pipeline side: issues requests, consumes completion and flags
  modport master (
    output start, flush, src_a, src_b, src_acc, accumulate, set_flags, old_cv,
    input  busy, done, result, alu_flags, flag_w
  );

  // Multiplier side
  modport slave (
    input  start, flush, src_a, src_b, src_acc, accumulate, set_flags, old_cv,
    output busy, done, result, alu_flags, flag_w
  );
endinterface

// File: rtl/mul_flag_unit.sv
// rtl/mul_flag_unit.sv - fixed-latency shift-add MUL/MLA unit acting as an alternate N,Z flag source
module mul_flag_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 5
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  mul_flag_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             setf_q, setf_d;
  logic [1:0]       oldcv_q, oldcv_d;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] acc_sum;

  // Partial-product step: add the shifted multiplicand when the current multiplier bit is set
  assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // State and datapath registers; reset clears everything including the held result and flags
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      setf_q   <= 1'b0;
      oldcv_q  <= 2'b00;
      flags_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      setf_q   <= setf_d;
      oldcv_q  <= oldcv_d;
      flags_q  <= flags_d;
    end
  end

  // Next-state and datapath update; result/flags only change on the final RUN iteration
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    setf_d   = setf_q;
    oldcv_d  = oldcv_q;
    flags_d  = flags_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          mcand_d  = bus.src_a;
          mplier_d = bus.src_b;
          acc_d    = bus.accumulate ? bus.src_acc : '0;
          setf_d   = bus.set_flags;
          oldcv_d  = bus.old_cv;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNTW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d  = S_DONE;
            result_d = acc_sum;
            flags_d  = {acc_sum[WIDTH-1], (acc_sum == '0), oldcv_q};
          end
        end
      end
      S_DONE: begin
        // Flush here cannot suppress the pulse already on the outputs; IDLE is next either way
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.alu_flags = flags_q;
  assign bus.flag_w    = (state_q == S_DONE) ? {setf_q, 1'b0} : 2'b00;

endmodule

// File: tb/tb_mul_flag_unit.sv
// tb/tb_mul_flag_unit.sv - self-checking bench for mul_flag_unit
module tb_mul_flag_unit;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mul_flag_unit_if #(.WIDTH(WIDTH)) bus ();

  mul_flag_unit #(.WIDTH(WIDTH), .CNTW(5)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout got=stuck exp=finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        accum;
    logic        sf;
    logic [1:0]  cv;
    logic [31:0] er;
    logic [3:0]  ef;
    logic [1:0]  efw;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic accum);
    logic [63:0] p;
    p = 64'(a) * 64'(b) + (accum ? 64'(c) : 64'd0);
    return p[31:0];
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic accum, input logic sf, input logic [1:0] cv,
                        input logic [31:0] er, input logic [3:0] ef, input logic [1:0] efw,
                        input string name);
    int n;
    bit seen;
    bit busy_ok;
    @(negedge clk);
    bus.src_a      = a;
    bus.src_b      = b;
    bus.src_acc    = c;
    bus.accumulate = accum;
    bus.set_flags  = sf;
    bus.old_cv     = cv;
    bus.flush      = 1'b0;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.src_a   = $urandom;
    bus.src_b   = $urandom;
    bus.src_acc = $urandom;
    n = 1;
    seen = 0;
    busy_ok = 1;
    while (!seen && n <= 40) begin
      if (bus.done) begin
        seen = 1;
      end else begin
        if (!bus.busy || bus.flag_w != 2'b00) busy_ok = 0;
        @(negedge clk);
        n++;
      end
    end
    chk({name, "_latency"}, 64'(n), 64'd33);
    chk({name, "_busy_run"}, 64'(busy_ok), 64'd1);
    chk({name, "_result"}, 64'(bus.result), 64'(er));
    chk({name, "_flags"}, 64'(bus.alu_flags), 64'(ef));
    chk({name, "_flagw"}, 64'(bus.flag_w), 64'(efw));
    chk({name, "_busy_done"}, 64'(bus.busy), 64'd1);
    @(negedge clk);
    chk({name, "_after"}, {62'd0, bus.busy, bus.done}, 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, rc, rr, prev;
    logic        racc, rsf;
    logic [1:0]  rcv;
    int          dcount, d1, d2;
    bit          ok;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.start = 1'b0; bus.flush = 1'b0;
    bus.src_a = '0; bus.src_b = '0; bus.src_acc = '0;
    bus.accumulate = 1'b0; bus.set_flags = 1'b0; bus.old_cv = 2'b00;

    vecs[0] = '{32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 2'b10, 32'd42, 4'b0010, 2'b10};
    vecs[1] = '{32'd3, 32'd4, 32'd5, 1'b1, 1'b0, 2'b00, 32'd17, 4'b0000, 2'b00};
    vecs[2] = '{32'h8000_0000, 32'd2, 32'd0, 1'b0, 1'b1, 2'b01, 32'd0, 4'b0101, 2'b10};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 2'b11, 32'd1, 4'b0011, 2'b10};
    vecs[4] = '{32'hFFFF_FFFF, 32'd1, 32'd1, 1'b1, 1'b1, 2'b00, 32'd0, 4'b0100, 2'b10};
    vecs[5] = '{32'hFFFF_FFFE, 32'd3, 32'd0, 1'b0, 1'b1, 2'b00, 32'hFFFF_FFFA, 4'b1000, 2'b10};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.busy, bus.done, bus.result, bus.alu_flags, bus.flag_w}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].accum, vecs[i].sf, vecs[i].cv,
             vecs[i].er, vecs[i].ef, vecs[i].efw, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = (i < 4) ? 32'($urandom_range(0, 15)) : $urandom; rc = $urandom;
      racc = 1'($urandom); rsf = 1'($urandom); rcv = 2'($urandom);
      rr = model_mul(ra, rb, rc, racc);
      run_op(ra, rb, rc, racc, rsf, rcv, rr, {rr[31], (rr == 32'd0), rcv}, {rsf, 1'b0},
             $sformatf("rnd%0d", i));
    end

    // Reset in the middle of RUN clears everything at once, then a normal op follows
    @(negedge clk);
    bus.src_a = 32'd5; bus.src_b = 32'd3; bus.accumulate = 1'b0; bus.set_flags = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset", {bus.busy, bus.done, bus.result, bus.alu_flags, bus.flag_w}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 2'b10, 32'd42, 4'b0010, 2'b10, "post_reset");

    // Flush at RUN cycle 10: no Done, result and flags kept from previous op
    prev = 32'd42;
    @(negedge clk);
    bus.src_a = 32'd9; bus.src_b = 32'd9; bus.set_flags = 1'b1; bus.old_cv = 2'b01;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_idle", 64'(bus.busy), 64'd0);
    ok = 1;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) ok = 0;
    end
    chk("flush_no_done", 64'(ok), 64'd1);
    chk("flush_result_held", 64'(bus.result), 64'(prev));
    chk("flush_flags_held", 64'(bus.alu_flags), 64'b0010);

    // Start and Flush together in IDLE: request dropped
    bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("start_flush_idle", {62'd0, bus.busy, bus.done}, 64'd0);

    // Start held high: one Done per op, second op accepted on first IDLE cycle after DONE
    bus.src_a = 32'd2; bus.src_b = 32'd3; bus.accumulate = 1'b0; bus.set_flags = 1'b0;
    bus.start = 1'b1;
    dcount = 0; d1 = 0; d2 = 0; ok = 1;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 40) bus.start = 1'b0;
      if (bus.done) begin
        dcount++;
        if (dcount == 1) d1 = n; else if (dcount == 2) d2 = n;
        if (bus.result != 32'd6) ok = 0;
      end
      if (n == 34 && bus.busy) ok = 0;
    end
    chk("held_done_count", 64'(dcount), 64'd2);
    chk("held_first_done", 64'(d1), 64'd33);
    chk("held_second_done", 64'(d2), 64'd67);
    chk("held_result_idle", 64'(ok), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
